// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: opcodes, ALU op encodings
// and the decoded control bundle that control_unit hands to ID/EX.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_XOR   = 3'b101,
        ALU_SLT   = 3'b110
    } alu_op_e;

    // Decoded control bundle; alu_op carries an alu_op_e encoding.
    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Strip every control that changes architectural state, leaving the
    // don't-care datapath selects untouched.
    function automatic ctrl_t kill_side_effects(input ctrl_t c);
        ctrl_t r;
        r           = c;
        r.reg_write = 1'b0;
        r.mem_read  = 1'b0;
        r.mem_write = 1'b0;
        r.branch    = 1'b0;
        r.jump      = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: an instruction in ID that reads
// the destination of a load currently in EX must wait one cycle.
module load_use_detect
    import mips_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      id_valid,
    input  logic [5:0]                id_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      ex_valid,
    input  logic                      ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
    output logic                      hazard
);

    logic uses_rs;
    logic uses_rt;

    // Source-operand decode and compare against the load's destination;
    // $zero is never a real dependency.
    always_comb begin
        uses_rs = (id_opcode != OP_J);
        uses_rt = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW) || (id_opcode == OP_BEQ);
        hazard  = id_valid && ex_valid && ex_mem_read && (ex_rt != '0) &&
                  ((uses_rs && (ex_rt == id_rs)) || (uses_rt && (ex_rt == id_rt)));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold,
// plus a saturating counter of inserted load-use bubbles.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [5:0]                id_opcode,
    input  logic [5:0]                id_funct,
    input  logic                      id_reg_dst,
    input  logic                      id_branch,
    input  logic                      id_mem_read,
    input  logic                      id_mem_to_reg,
    input  logic                      id_mem_write,
    input  logic                      id_alu_src,
    input  logic                      id_reg_write,
    input  logic                      id_jump,
    input  logic [2:0]                id_alu_op,
    input  logic [DATA_WIDTH-1:0]     id_pc_plus4,
    input  logic [DATA_WIDTH-1:0]     id_rs_data,
    input  logic [DATA_WIDTH-1:0]     id_rt_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      flush,
    input  logic                      hold,
    output logic                      ex_valid,
    output logic [5:0]                ex_funct,
    output logic                      ex_reg_dst,
    output logic                      ex_branch,
    output logic                      ex_mem_read,
    output logic                      ex_mem_to_reg,
    output logic                      ex_mem_write,
    output logic                      ex_alu_src,
    output logic                      ex_reg_write,
    output logic                      ex_jump,
    output logic [2:0]                ex_alu_op,
    output logic [DATA_WIDTH-1:0]     ex_pc_plus4,
    output logic [DATA_WIDTH-1:0]     ex_rs_data,
    output logic [DATA_WIDTH-1:0]     ex_rt_data,
    output logic [DATA_WIDTH-1:0]     ex_imm,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs,
    output logic [REG_ADDR_WIDTH-1:0] ex_rt,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      stall,
    output logic [CNT_WIDTH-1:0]      bubble_count
);

    ctrl_t                     id_ctrl;
    ctrl_t                     ctrl_reg, ctrl_next;
    logic                      valid_reg, valid_next;
    logic [5:0]                funct_reg, funct_next;
    logic [DATA_WIDTH-1:0]     pc_plus4_reg, pc_plus4_next;
    logic [DATA_WIDTH-1:0]     rs_data_reg, rs_data_next;
    logic [DATA_WIDTH-1:0]     rt_data_reg, rt_data_next;
    logic [DATA_WIDTH-1:0]     imm_reg, imm_next;
    logic [REG_ADDR_WIDTH-1:0] rs_reg, rs_next;
    logic [REG_ADDR_WIDTH-1:0] rt_reg, rt_next;
    logic [REG_ADDR_WIDTH-1:0] rd_reg, rd_next;
    logic [CNT_WIDTH-1:0]      bubble_count_reg, bubble_count_next;
    logic                      hazard;

    assign id_ctrl = '{reg_dst:    id_reg_dst,
                       branch:     id_branch,
                       mem_read:   id_mem_read,
                       mem_to_reg: id_mem_to_reg,
                       mem_write:  id_mem_write,
                       alu_src:    id_alu_src,
                       reg_write:  id_reg_write,
                       jump:       id_jump,
                       alu_op:     id_alu_op};

    load_use_detect #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_load_use_detect (
        .id_valid   (id_valid),
        .id_opcode  (id_opcode),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_valid   (valid_reg),
        .ex_mem_read(ctrl_reg.mem_read),
        .ex_rt      (rt_reg),
        .hazard     (hazard)
    );

    // The front end freezes both for a load-use bubble and for a downstream hold.
    assign stall = hazard | hold;

    // Next-state selection: flush beats hold, hold beats hazard, hazard beats load.
    always_comb begin
        ctrl_next         = ctrl_reg;
        valid_next        = valid_reg;
        funct_next        = funct_reg;
        pc_plus4_next     = pc_plus4_reg;
        rs_data_next      = rs_data_reg;
        rt_data_next      = rt_data_reg;
        imm_next          = imm_reg;
        rs_next           = rs_reg;
        rt_next           = rt_reg;
        rd_next           = rd_reg;
        bubble_count_next = bubble_count_reg;
        if (flush || (!hold && hazard)) begin
            ctrl_next     = CTRL_NOP;
            valid_next    = 1'b0;
            funct_next    = '0;
            pc_plus4_next = '0;
            rs_data_next  = '0;
            rt_data_next  = '0;
            imm_next      = '0;
            rs_next       = '0;
            rt_next       = '0;
            rd_next       = '0;
            // A flushed slot is not a load-use bubble, so only count the latter.
            if (!flush && bubble_count_reg != '1) begin
                bubble_count_next = bubble_count_reg + CNT_WIDTH'(1);
            end
        end else if (!hold) begin
            ctrl_next     = id_valid ? id_ctrl : kill_side_effects(id_ctrl);
            valid_next    = id_valid;
            funct_next    = id_funct;
            pc_plus4_next = id_pc_plus4;
            rs_data_next  = id_rs_data;
            rt_data_next  = id_rt_data;
            imm_next      = id_imm;
            rs_next       = id_rs;
            rt_next       = id_rt;
            rd_next       = id_rd;
        end
    end

    // Pipeline register and bubble counter, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg         <= CTRL_NOP;
            valid_reg        <= 1'b0;
            funct_reg        <= '0;
            pc_plus4_reg     <= '0;
            rs_data_reg      <= '0;
            rt_data_reg      <= '0;
            imm_reg          <= '0;
            rs_reg           <= '0;
            rt_reg           <= '0;
            rd_reg           <= '0;
            bubble_count_reg <= '0;
        end else begin
            ctrl_reg         <= ctrl_next;
            valid_reg        <= valid_next;
            funct_reg        <= funct_next;
            pc_plus4_reg     <= pc_plus4_next;
            rs_data_reg      <= rs_data_next;
            rt_data_reg      <= rt_data_next;
            imm_reg          <= imm_next;
            rs_reg           <= rs_next;
            rt_reg           <= rt_next;
            rd_reg           <= rd_next;
            bubble_count_reg <= bubble_count_next;
        end
    end

    assign ex_valid      = valid_reg;
    assign ex_funct      = funct_reg;
    assign ex_reg_dst    = ctrl_reg.reg_dst;
    assign ex_branch     = ctrl_reg.branch;
    assign ex_mem_read   = ctrl_reg.mem_read;
    assign ex_mem_to_reg = ctrl_reg.mem_to_reg;
    assign ex_mem_write  = ctrl_reg.mem_write;
    assign ex_alu_src    = ctrl_reg.alu_src;
    assign ex_reg_write  = ctrl_reg.reg_write;
    assign ex_jump       = ctrl_reg.jump;
    assign ex_alu_op     = ctrl_reg.alu_op;
    assign ex_pc_plus4   = pc_plus4_reg;
    assign ex_rs_data    = rs_data_reg;
    assign ex_rt_data    = rt_data_reg;
    assign ex_imm        = imm_reg;
    assign ex_rs         = rs_reg;
    assign ex_rt         = rt_reg;
    assign ex_rd         = rd_reg;
    assign bubble_count  = bubble_count_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table plus randomized traffic
// checked against a behavioural model of the stage.
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, hold;
    logic id_valid, id_reg_dst, id_branch, id_mem_read, id_mem_to_reg;
    logic id_mem_write, id_alu_src, id_reg_write, id_jump;
    logic [5:0] id_opcode, id_funct;
    logic [2:0] id_alu_op;
    logic [DW-1:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic ex_valid, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg;
    logic ex_mem_write, ex_alu_src, ex_reg_write, ex_jump, stall;
    logic [5:0] ex_funct;
    logic [2:0] ex_alu_op;
    logic [DW-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [CW-1:0] bubble_count;

    id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct(id_funct), .id_reg_dst(id_reg_dst), .id_branch(id_branch),
        .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_jump(id_jump), .id_alu_op(id_alu_op),
        .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .hold(hold), .ex_valid(ex_valid), .ex_funct(ex_funct),
        .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_jump(ex_jump),
        .ex_alu_op(ex_alu_op), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .stall(stall), .bubble_count(bubble_count)
    );

    typedef struct packed {
        logic          valid;
        logic [5:0]    opcode;
        logic [5:0]    funct;
        logic          reg_dst, branch, mem_read, mem_to_reg;
        logic          mem_write, alu_src, reg_write, jump;
        logic [2:0]    alu_op;
        logic [DW-1:0] pc4, rs_data, rt_data, imm;
        logic [AW-1:0] rs, rt, rd;
    } id_t;

    typedef struct {
        logic          rst, flush, hold;
        id_t           in;
        logic          chk_stall, exp_stall, exp_valid, exp_reg_write;
        logic [AW-1:0] exp_rs;
        logic [DW-1:0] exp_imm;
        logic [CW-1:0] exp_count;
    } vec_t;

    int tests = 0;
    int failed = 0;

    // Behavioural model: what EX should hold, and the bubble count.
    id_t m_ex;
    int  m_count;
    id_t cur;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Control bundle a control_unit would produce for each opcode.
    function automatic id_t mk(input logic [5:0] op, input int rs, input int rt,
                               input int rd, input logic [31:0] imm, input logic v);
        id_t d;
        d        = '0;
        d.valid  = v;
        d.opcode = op;
        d.funct  = (op == OP_RTYPE) ? 6'h20 : 6'h00;
        d.rs     = AW'(rs);
        d.rt     = AW'(rt);
        d.rd     = AW'(rd);
        d.imm    = imm;
        d.pc4    = $urandom;
        d.rs_data = $urandom;
        d.rt_data = $urandom;
        case (op)
            OP_RTYPE: begin d.reg_dst = 1; d.reg_write = 1; d.alu_op = 3'b010; end
            OP_LW:    begin d.alu_src = 1; d.mem_read = 1; d.mem_to_reg = 1; d.reg_write = 1; end
            OP_SW:    begin d.alu_src = 1; d.mem_write = 1; end
            OP_BEQ:   begin d.branch = 1; d.alu_op = 3'b001; end
            OP_ADDI:  begin d.alu_src = 1; d.reg_write = 1; end
            OP_ANDI:  begin d.alu_src = 1; d.reg_write = 1; d.alu_op = 3'b011; end
            OP_ORI:   begin d.alu_src = 1; d.reg_write = 1; d.alu_op = 3'b100; end
            OP_XORI:  begin d.alu_src = 1; d.reg_write = 1; d.alu_op = 3'b101; end
            OP_SLTI:  begin d.alu_src = 1; d.reg_write = 1; d.alu_op = 3'b110; end
            OP_J:     begin d.jump = 1; end
            default:  ;
        endcase
        return d;
    endfunction

    // Load-use rule: ID reads the register a load in EX is about to write.
    function automatic logic m_hazard(input id_t id);
        logic reads_rs, reads_rt;
        reads_rs = (id.opcode != 6'b000010);
        reads_rt = (id.opcode == 6'b000000) || (id.opcode == 6'b101011) || (id.opcode == 6'b000100);
        return id.valid && m_ex.valid && m_ex.mem_read && (m_ex.rt != 0) &&
               ((reads_rs && m_ex.rt == id.rs) || (reads_rt && m_ex.rt == id.rt));
    endfunction

    task automatic drive(input logic r, input logic f, input logic h, input id_t d);
        rst = r; flush = f; hold = h; cur = d;
        id_valid = d.valid; id_opcode = d.opcode; id_funct = d.funct;
        id_reg_dst = d.reg_dst; id_branch = d.branch; id_mem_read = d.mem_read;
        id_mem_to_reg = d.mem_to_reg; id_mem_write = d.mem_write;
        id_alu_src = d.alu_src; id_reg_write = d.reg_write; id_jump = d.jump;
        id_alu_op = d.alu_op; id_pc_plus4 = d.pc4; id_rs_data = d.rs_data;
        id_rt_data = d.rt_data; id_imm = d.imm; id_rs = d.rs; id_rt = d.rt; id_rd = d.rd;
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_edge();
        id_t nx;
        int  nc;
        nx = m_ex;
        nc = m_count;
        if (rst) begin
            nx = '0; nc = 0;
        end else if (flush) begin
            nx = '0;
        end else if (hold) begin
            nx = m_ex;
        end else if (m_hazard(cur)) begin
            nx = '0;
            nc = (m_count >= CMAX) ? CMAX : m_count + 1;
        end else begin
            nx = cur;
            nx.opcode = '0;
            if (!cur.valid) begin
                nx.reg_write = 0; nx.mem_read = 0; nx.mem_write = 0;
                nx.branch = 0; nx.jump = 0;
            end
        end
        m_ex = nx;
        m_count = nc;
    endtask

    task automatic check_model(input string tag);
        logic [191:0] dv, mv;
        dv = 192'({ex_valid, ex_funct, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg,
                   ex_mem_write, ex_alu_src, ex_reg_write, ex_jump, ex_alu_op, ex_pc_plus4,
                   ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd});
        mv = 192'({m_ex.valid, m_ex.funct, m_ex.reg_dst, m_ex.branch, m_ex.mem_read,
                   m_ex.mem_to_reg, m_ex.mem_write, m_ex.alu_src, m_ex.reg_write, m_ex.jump,
                   m_ex.alu_op, m_ex.pc4, m_ex.rs_data, m_ex.rt_data, m_ex.imm,
                   m_ex.rs, m_ex.rt, m_ex.rd});
        check({tag, " ex_bundle"}, dv, mv);
        check({tag, " bubble_count"}, 192'(bubble_count), 192'(m_count));
    endtask

    vec_t vecs[$];

    function automatic vec_t row(input logic r, input logic f, input logic h, input id_t d,
                                 input logic cs, input logic es, input logic ev,
                                 input logic ew, input int ers, input logic [31:0] ei,
                                 input int ec);
        vec_t v;
        v.rst = r; v.flush = f; v.hold = h; v.in = d;
        v.chk_stall = cs; v.exp_stall = es; v.exp_valid = ev; v.exp_reg_write = ew;
        v.exp_rs = AW'(ers); v.exp_imm = ei; v.exp_count = CW'(ec);
        return v;
    endfunction

    initial begin
        id_t ones;
        ones = '1;
        m_ex = '0;
        m_count = 0;

        //                 rst flush hold  instruction                          chk stl vld rw rs imm      cnt
        vecs.push_back(row(1, 0, 0, ones,                                        0, 0, 0, 0, 0, 32'h0,  0));
        vecs.push_back(row(1, 0, 0, ones,                                        1, 0, 0, 0, 0, 32'h0,  0));
        vecs.push_back(row(0, 0, 0, mk(OP_ADDI, 3, 4, 0, 32'h10, 1),             1, 0, 1, 1, 3, 32'h10, 0));
        vecs.push_back(row(0, 0, 0, mk(OP_LW, 1, 5, 0, 32'h4, 1),                1, 0, 1, 1, 1, 32'h4,  0));
        vecs.push_back(row(0, 0, 0, mk(OP_RTYPE, 5, 6, 7, 32'h0, 1),             1, 1, 0, 0, 0, 32'h0,  1));
        vecs.push_back(row(0, 0, 0, mk(OP_RTYPE, 5, 6, 7, 32'h0, 1),             1, 0, 1, 1, 5, 32'h0,  1));
        vecs.push_back(row(0, 0, 0, mk(OP_LW, 2, 0, 0, 32'h8, 1),                1, 0, 1, 1, 2, 32'h8,  1));
        vecs.push_back(row(0, 0, 0, mk(OP_RTYPE, 0, 0, 3, 32'h0, 1),             1, 0, 1, 1, 0, 32'h0,  1));
        vecs.push_back(row(0, 0, 0, mk(OP_LW, 1, 7, 0, 32'hc, 1),                1, 0, 1, 1, 1, 32'hc,  1));
        vecs.push_back(row(0, 0, 0, mk(OP_ADDI, 2, 7, 0, 32'h1, 1),              1, 0, 1, 1, 2, 32'h1,  1));
        vecs.push_back(row(0, 0, 0, mk(OP_LW, 1, 7, 0, 32'hc, 1),                1, 0, 1, 1, 1, 32'hc,  1));
        vecs.push_back(row(0, 0, 0, mk(OP_SW, 2, 7, 0, 32'h20, 1),               1, 1, 0, 0, 0, 32'h0,  2));
        vecs.push_back(row(0, 0, 0, mk(OP_SW, 2, 7, 0, 32'h20, 1),               1, 0, 1, 0, 2, 32'h20, 2));
        vecs.push_back(row(0, 0, 0, mk(OP_LW, 1, 9, 0, 32'h30, 1),               1, 0, 1, 1, 1, 32'h30, 2));
        vecs.push_back(row(0, 1, 0, mk(OP_RTYPE, 9, 1, 2, 32'h0, 1),             1, 1, 0, 0, 0, 32'h0,  2));
        vecs.push_back(row(0, 0, 0, mk(OP_LW, 1, 9, 0, 32'h30, 1),               1, 0, 1, 1, 1, 32'h30, 2));
        vecs.push_back(row(0, 1, 1, mk(OP_ADDI, 3, 4, 0, 32'h10, 1),             1, 1, 0, 0, 0, 32'h0,  2));
        vecs.push_back(row(0, 0, 0, mk(OP_ADDI, 3, 4, 0, 32'h10, 1),             1, 0, 1, 1, 3, 32'h10, 2));
        for (int k = 0; k < 3; k++)
            vecs.push_back(row(0, 0, 1, mk(OP_LW, 1, 10, 0, 32'h40, 1),          1, 1, 1, 1, 3, 32'h10, 2));
        vecs.push_back(row(0, 0, 0, mk(OP_LW, 1, 10, 0, 32'h40, 1),              1, 0, 1, 1, 1, 32'h40, 2));
        vecs.push_back(row(0, 0, 1, mk(OP_RTYPE, 10, 2, 3, 32'h0, 1),            1, 1, 1, 1, 1, 32'h40, 2));
        vecs.push_back(row(0, 0, 0, mk(OP_RTYPE, 10, 2, 3, 32'h0, 1),            1, 1, 0, 0, 0, 32'h0,  3));
        vecs.push_back(row(0, 0, 0, mk(OP_RTYPE, 10, 2, 3, 32'h0, 1),            1, 0, 1, 1, 10, 32'h0, 3));
        vecs.push_back(row(0, 0, 0, mk(OP_LW, 1, 5, 0, 32'h50, 0),               1, 0, 0, 0, 1, 32'h50, 3));
        vecs.push_back(row(0, 0, 0, mk(OP_RTYPE, 5, 6, 7, 32'h0, 1),             1, 0, 1, 1, 5, 32'h0,  3));
        // Five more load-use pairs: the counter must hold at its ceiling.
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(row(0, 0, 0, mk(OP_LW, 1, 5, 0, 32'h4, 1),            1, 0, 1, 1, 1, 32'h4,  3));
            vecs.push_back(row(0, 0, 0, mk(OP_RTYPE, 5, 6, 7, 32'h0, 1),         1, 1, 0, 0, 0, 32'h0,  3));
        end
        // Reset arriving during a hazard clears everything, no bubble counted.
        vecs.push_back(row(0, 0, 0, mk(OP_LW, 1, 5, 0, 32'h4, 1),                1, 0, 1, 1, 1, 32'h4,  3));
        vecs.push_back(row(1, 0, 0, mk(OP_RTYPE, 5, 6, 7, 32'h0, 1),             1, 1, 0, 0, 0, 32'h0,  0));

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("row%0d", i);
            drive(vecs[i].rst, vecs[i].flush, vecs[i].hold, vecs[i].in);
            @(negedge clk);
            if (vecs[i].chk_stall) begin
                check({t, " stall"}, 192'(stall), 192'(vecs[i].exp_stall));
                check({t, " stall_model"}, 192'(stall), 192'(m_hazard(cur) | hold));
            end
            @(posedge clk);
            model_edge();
            #1;
            check({t, " ex_valid"}, 192'(ex_valid), 192'(vecs[i].exp_valid));
            check({t, " ex_reg_write"}, 192'(ex_reg_write), 192'(vecs[i].exp_reg_write));
            check({t, " ex_rs"}, 192'(ex_rs), 192'(vecs[i].exp_rs));
            check({t, " ex_imm"}, 192'(ex_imm), 192'(vecs[i].exp_imm));
            check({t, " count"}, 192'(bubble_count), 192'(vecs[i].exp_count));
            check_model(t);
            $display("[TB] row %0d rst=%0b flush=%0b hold=%0b op=%02h stall=%0b ex_valid=%0b cnt=%0d",
                     i, vecs[i].rst, vecs[i].flush, vecs[i].hold, vecs[i].in.opcode,
                     vecs[i].exp_stall, ex_valid, bubble_count);
        end

        // Randomized traffic over a small register set to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            logic [5:0] ops [10];
            id_t d;
            string t;
            logic r, f, h;
            ops = '{OP_RTYPE, OP_LW, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J};
            d = mk(ops[$urandom_range(9)], $urandom_range(3), $urandom_range(3),
                   $urandom_range(31), $urandom, ($urandom_range(9) != 0));
            r = ($urandom_range(49) == 0);
            f = ($urandom_range(9) == 0);
            h = ($urandom_range(7) == 0);
            t = $sformatf("rand%0d", n);
            drive(r, f, h, d);
            @(negedge clk);
            check({t, " stall"}, 192'(stall), 192'(m_hazard(cur) | hold));
            @(posedge clk);
            model_edge();
            #1;
            check_model(t);
            $display("[TB] rand %0d rst=%0b flush=%0b hold=%0b op=%02h rs=%0d rt=%0d ex_valid=%0b cnt=%0d",
                     n, r, f, h, d.opcode, d.rs, d.rt, ex_valid, bubble_count);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
